// File: rtl/pulse_conditioner.sv
// pulse_conditioner: synchronises an asynchronous detector input, rejects glitches
// shorter than FILTER_LEN cycles, emits one 1-cycle pulse per accepted event and
// enforces a dead-time afterwards. Accepted events are counted, saturating.
// Optional feature macro: PULSE_COND_REJECT_CNT_EN adds the reject_count port and
// its counter; without it the block is otherwise identical.
module pulse_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int DEADTIME    = 20,
    parameter int INVERT      = 1,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signal_in,
    input  logic               enable,
    input  logic               count_clear,
    output logic               pulse_out,
    output logic               busy,
    output logic [COUNT_W-1:0] event_count
`ifdef PULSE_COND_REJECT_CNT_EN
    ,
    output logic [COUNT_W-1:0] reject_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        HOLDOFF = 2'd2,
        REARM   = 2'd3
    } state_t;

    localparam int QW = $clog2(FILTER_LEN + 1);
    localparam int DW = $clog2(DEADTIME + 1);
    localparam logic [QW-1:0]      QUAL_LAST = QW'(FILTER_LEN - 1);
    localparam logic [DW-1:0]      DEAD_LAST = DW'(DEADTIME - 1);
    localparam logic               INV       = 1'(INVERT);
    localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] r_rst_sync;
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [QW-1:0]          r_qual_cnt;
    logic [DW-1:0]          r_dead_cnt;
    logic                   r_pulse;
    logic [COUNT_W-1:0]     r_event_count;

    logic                   w_rst_n;
    logic                   w_s;
    state_t                 w_state_next;
    logic [QW-1:0]          w_qual_next;
    logic [DW-1:0]          w_dead_next;
    logic                   w_pulse_next;
    logic                   w_reject;

    // Reset release is delayed by SYNC_STAGES clocks so that the input chain, which
    // leaves reset on the raw rst, already holds the live input when the FSM starts;
    // the FSM therefore never sees the all-zero reset contents as a phantom event.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!rst) r_rst_sync <= '0;
        else      r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[SYNC_STAGES-1];

    // Input synchroniser chain for the asynchronous detector level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '0;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], signal_in};
    end

    assign w_s = r_sync[SYNC_STAGES-1] ^ INV;

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= IDLE;
            r_qual_cnt <= '0;
            r_dead_cnt <= '0;
            r_pulse    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_qual_cnt <= w_qual_next;
            r_dead_cnt <= w_dead_next;
            r_pulse    <= w_pulse_next;
        end
    end

    // Next-state logic; enable=0 overrides everything and abandons the event.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        w_state_next = r_state;
        w_qual_next  = r_qual_cnt;
        w_dead_next  = r_dead_cnt;
        w_reject     = 1'b0;
        if (!enable) begin
            w_state_next = IDLE;
            w_qual_next  = '0;
            w_dead_next  = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_s) begin
                        if (FILTER_LEN == 1) begin
                            w_state_next = HOLDOFF;
                            w_dead_next  = '0;
                        end else begin
                            w_state_next = QUALIFY;
                            w_qual_next  = QW'(1);
                        end
                    end
                end
                QUALIFY: begin
                    if (!w_s) begin
                        w_state_next = IDLE;
                        w_qual_next  = '0;
                        w_reject     = 1'b1;
                    end else if (r_qual_cnt == QUAL_LAST) begin
                        w_state_next = HOLDOFF;
                        w_dead_next  = '0;
                    end else begin
                        w_qual_next = r_qual_cnt + QW'(1);
                    end
                end
                HOLDOFF: begin
                    if (r_dead_cnt == DEAD_LAST) w_state_next = REARM;
                    else                         w_dead_next  = r_dead_cnt + DW'(1);
                end
                REARM: begin
                    if (!w_s) w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // The pulse is registered: it is high exactly in the first HOLDOFF cycle.
    assign w_pulse_next = (w_state_next == HOLDOFF) && (r_state != HOLDOFF);

    // Accepted-event counter; it steps on the same edge that raises pulse_out.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)                                r_event_count <= '0;
        else if (count_clear)                        r_event_count <= '0;
        else if (w_pulse_next && r_event_count != CNT_MAX) r_event_count <= r_event_count + 1'b1;
    end

`ifdef PULSE_COND_REJECT_CNT_EN
    logic [COUNT_W-1:0] r_reject_count;

    // Glitch counter; only aborts caused by the input dropping are counted.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)                                r_reject_count <= '0;
        else if (count_clear)                        r_reject_count <= '0;
        else if (w_reject && r_reject_count != CNT_MAX) r_reject_count <= r_reject_count + 1'b1;
    end

    assign reject_count = r_reject_count;
`endif

    assign pulse_out   = r_pulse;
    assign busy        = (r_state != IDLE);
    assign event_count = r_event_count;

endmodule
